// File: rtl/sramlike_bus_arbiter_if.sv
// sramlike_bus_arbiter_if
// One sram-like bus: a request side (req/wr/size/addr/wdata) and a response
// side (addr_ok/data_ok/rdata).
//   modport master : drives the request, receives the handshakes
//   modport slave  : receives the request, drives the handshakes
// size encoding: 00 byte, 01 half, 10 word.
interface sramlike_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sramlike_bus_arbiter.sv
// sramlike_bus_arbiter
// Shares one sram-like slave port between the instruction-side bridge
// (master I) and the data-side bridge (master D). Address handshakes are
// serialised onto the slave, the owner of every accepted request is queued
// in issue order, and each data_ok/rdata is steered back to the master at
// the head of that queue. Zero added latency on both request and return.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   i_bus         slave modport, master I (instruction side)
//   d_bus         slave modport, master D (data side)
//   s_bus         master modport, toward the sram-like-to-AXI converter
//   outstanding   accepted-but-not-returned transaction count
//   protocol_err  sticky: data_ok with nothing outstanding, or a locked
//                 master dropped req before its address was accepted
//
// Parameters:
//   MAX_OUT  max outstanding transactions (power of two, 2..16)
//   OWN_W    width of the owner tag per outstanding entry (0=I, 1=D)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous requests from an
//                       unlocked state go to the master that did not win
//                       the previous address handshake (last_grant resets
//                       to D). Undefined: fixed D-over-I priority.
module sramlike_bus_arbiter #(
  parameter int MAX_OUT = 4,
  parameter int OWN_W   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  sramlike_bus_arbiter_if.slave     i_bus,
  sramlike_bus_arbiter_if.slave     d_bus,
  sramlike_bus_arbiter_if.master    s_bus,
  output logic [$clog2(MAX_OUT):0]  outstanding,
  output logic                      protocol_err
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [OWN_W-1:0] own_t;
  localparam own_t OWN_I = own_t'(0);
  localparam own_t OWN_D = own_t'(1);

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} lock_state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  lock_state_t       state_q, state_d;
  own_t              lock_id_q, lock_id_d;
  logic              lock_valid;
  logic              lock_drop;

  own_t              tag_q [MAX_OUT];
  logic [PTR_W-1:0]  wp_q, rp_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

`ifdef ARB_ROUND_ROBIN_EN
  own_t              last_grant_q;
`endif

  // ---------------------------------------------------------------------
  // Owner selection
  // ---------------------------------------------------------------------
  logic  has_owner;
  own_t  owner;
  logic  owner_is_d;
  logic  owner_req;
  logic  full, empty;
  logic  s_req;
  logic  push, pop;
  own_t  head;
  req_t  i_r, d_r, s_r;

  assign lock_valid = (state_q == HOLD);
  assign full       = (cnt_q == CNT_W'(MAX_OUT));
  assign empty      = (cnt_q == '0);
  assign head       = tag_q[rp_q];

  always_comb begin
    has_owner = 1'b1;
    owner     = OWN_I;
    if (lock_valid) begin
      // a pending unacknowledged request keeps its grant
      owner = lock_id_q;
    end else if (d_bus.req && i_bus.req) begin
`ifdef ARB_ROUND_ROBIN_EN
      owner = (last_grant_q == OWN_D) ? OWN_I : OWN_D;
`else
      owner = OWN_D;
`endif
    end else if (d_bus.req) begin
      owner = OWN_D;
    end else if (i_bus.req) begin
      owner = OWN_I;
    end else begin
      has_owner = 1'b0;
    end
  end

  assign owner_is_d = (owner == OWN_D);
  assign owner_req  = has_owner & (owner_is_d ? d_bus.req : i_bus.req);

  // ---------------------------------------------------------------------
  // Slave forwarding; with no owner the fields follow master I
  // ---------------------------------------------------------------------
  assign i_r = '{wr: i_bus.wr, size: i_bus.size, addr: i_bus.addr, wdata: i_bus.wdata};
  assign d_r = '{wr: d_bus.wr, size: d_bus.size, addr: d_bus.addr, wdata: d_bus.wdata};
  assign s_r = (has_owner && owner_is_d) ? d_r : i_r;

  // handshakes are held low while reset is asserted
  assign s_req       = ~rst & owner_req & ~full;
  assign s_bus.req   = s_req;
  assign s_bus.wr    = s_r.wr;
  assign s_bus.size  = s_r.size;
  assign s_bus.addr  = s_r.addr;
  assign s_bus.wdata = s_r.wdata;

  assign push = s_req & s_bus.addr_ok;
  assign pop  = ~rst & s_bus.data_ok & ~empty;

  assign i_bus.addr_ok = push & ~owner_is_d;
  assign d_bus.addr_ok = push &  owner_is_d;

  // ---------------------------------------------------------------------
  // Return routing: combinational, steered by the queue head
  // ---------------------------------------------------------------------
  assign i_bus.data_ok = pop & (head == OWN_I);
  assign d_bus.data_ok = pop & (head == OWN_D);
  assign i_bus.rdata   = s_bus.rdata;
  assign d_bus.rdata   = s_bus.rdata;

  // ---------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lock_id_q <= OWN_I;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    lock_drop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_req && !s_bus.addr_ok) begin
          state_d   = HOLD;
          lock_id_d = owner;
        end
      end
      HOLD: begin
        // locked master withdrew its request before it was accepted
        if (!owner_req) begin
          state_d   = IDLE;
          lock_drop = 1'b1;
        end else if (s_req && s_bus.addr_ok) begin
          state_d = IDLE;
        end
        // while full, s_req is 0 and the lock simply persists
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Order FIFO of owner tags. A push and pop in the same cycle both take
  // effect; a data_ok on an empty queue is dropped but a same-cycle push
  // is still recorded.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        tag_q[wp_q] <= owner;
        wp_q        <= wp_q + PTR_W'(1);
      end
      if (pop) rp_q <= rp_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign outstanding = cnt_q;

  // ---------------------------------------------------------------------
  // Sticky protocol error
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)                                   err_q <= 1'b0;
    else if ((s_bus.data_ok && empty) || lock_drop) err_q <= 1'b1;
  end

  assign protocol_err = err_q;

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)       last_grant_q <= OWN_D;
    else if (push) last_grant_q <= owner;
  end
`endif

endmodule

// File: tb/tb_sramlike_bus_arbiter.sv
module tb_sramlike_bus_arbiter;
  localparam int MAX_OUT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] outstanding;
  logic       protocol_err;

  always #5 clk = ~clk;

  sramlike_bus_arbiter_if i_if();
  sramlike_bus_arbiter_if d_if();
  sramlike_bus_arbiter_if s_if();

  sramlike_bus_arbiter #(.MAX_OUT(MAX_OUT), .OWN_W(1)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_bus        (i_if),
    .d_bus        (d_if),
    .s_bus        (s_if),
    .outstanding  (outstanding),
    .protocol_err (protocol_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------
  // Reference model: queue of owners (0=I, 1=D) in issue order plus the
  // "granted but not yet accepted" master.
  // -------------------------------------------------------------------
  int          mq[$];
  bit          m_hold = 0;
  int          m_hold_id = 0;
  bit          m_err = 0;
  int          m_last = 1;
  int          m_own;
  bit          m_oreq, m_full, m_sreq, m_dok;
  logic [31:0] m_addr, m_wdata;
  logic        m_wr;

  always @(negedge clk) begin
    m_own = -1;
    if (m_hold) m_own = m_hold_id;
    else if (d_if.req && i_if.req) begin
`ifdef ARB_ROUND_ROBIN_EN
      m_own = (m_last == 1) ? 0 : 1;
`else
      m_own = 1;
`endif
    end
    else if (d_if.req) m_own = 1;
    else if (i_if.req) m_own = 0;

    m_oreq  = (m_own == 1) ? d_if.req : (m_own == 0) ? i_if.req : 1'b0;
    m_full  = (mq.size() == MAX_OUT);
    m_sreq  = !rst && m_oreq && !m_full;
    m_addr  = (m_own == 1) ? d_if.addr  : i_if.addr;
    m_wdata = (m_own == 1) ? d_if.wdata : i_if.wdata;
    m_wr    = (m_own == 1) ? d_if.wr    : i_if.wr;
    m_dok   = !rst && s_if.data_ok && (mq.size() != 0);

    chk("m_s_req",     s_if.req, m_sreq);
    chk("m_s_addr",    s_if.addr, m_addr);
    chk("m_s_wdata",   s_if.wdata, m_wdata);
    chk("m_s_wr",      s_if.wr, m_wr);
    chk("m_i_addr_ok", i_if.addr_ok, m_sreq && s_if.addr_ok && m_own == 0);
    chk("m_d_addr_ok", d_if.addr_ok, m_sreq && s_if.addr_ok && m_own == 1);
    chk("m_i_data_ok", i_if.data_ok, m_dok && mq[0] == 0);
    chk("m_d_data_ok", d_if.data_ok, m_dok && mq[0] == 1);
    chk("m_i_rdata",   i_if.rdata, s_if.rdata);
    chk("m_d_rdata",   d_if.rdata, s_if.rdata);
    chk("m_outstanding", 32'(outstanding), mq.size());
    chk("m_protocol_err", protocol_err, m_err);

    if (rst) begin
      mq.delete();
      m_hold = 0;
      m_err  = 0;
      m_last = 1;
    end else begin
      if (s_if.data_ok) begin
        if (mq.size() == 0) m_err = 1;
        else void'(mq.pop_front());
      end
      if (m_hold && !m_oreq) begin
        m_hold = 0;
        m_err  = 1;
      end else if (m_sreq && s_if.addr_ok) begin
        mq.push_back(m_own);
        m_last = m_own;
        m_hold = 0;
      end else if (m_sreq) begin
        m_hold    = 1;
        m_hold_id = m_own;
      end
    end
  end

  // -------------------------------------------------------------------
  // Directed stimulus with hand-computed expectations
  // -------------------------------------------------------------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle();
    i_if.req = 0; d_if.req = 0;
    s_if.addr_ok = 0; s_if.data_ok = 0;
  endtask

  initial begin
    rst = 1;
    i_if.req = 1; i_if.wr = 0; i_if.size = 2'b10; i_if.addr = 32'h1FC0_0000; i_if.wdata = 32'h0;
    d_if.req = 0; d_if.wr = 0; d_if.size = 2'b10; d_if.addr = 32'h0; d_if.wdata = 32'h0;
    s_if.addr_ok = 1; s_if.data_ok = 0; s_if.rdata = 32'h0;

    // reset: handshakes held low
    neg();
    chk("rst_s_req", s_if.req, 1'b0);
    chk("rst_i_addr_ok", i_if.addr_ok, 1'b0);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_err", protocol_err, 1'b0);
    nxt();
    rst = 0; idle();
    nxt();

    // single read
    i_if.req = 1; i_if.addr = 32'h1FC0_0000; s_if.addr_ok = 1;
    neg();
    chk("rd_i_addr_ok", i_if.addr_ok, 1'b1);
    chk("rd_s_addr", s_if.addr, 32'h1FC0_0000);
    nxt(); idle();
    neg(); chk("rd_out1", 32'(outstanding), 1);
    chk("rd_i_addr_ok_once", i_if.addr_ok, 1'b0);
    nxt();
    s_if.data_ok = 1; s_if.rdata = 32'hDEAD_BEEF;
    neg();
    chk("rd_i_data_ok", i_if.data_ok, 1'b1);
    chk("rd_i_rdata", i_if.rdata, 32'hDEAD_BEEF);
    chk("rd_d_data_ok", d_if.data_ok, 1'b0);
    nxt(); idle();
    neg(); chk("rd_out0", 32'(outstanding), 0);
    nxt();

    // contention, slave stalls 3 cycles
    i_if.req = 1; i_if.addr = 32'h0000_1000;
    d_if.req = 1; d_if.wr = 1; d_if.addr = 32'h8000_0010; d_if.wdata = 32'h55AA_1234;
    s_if.addr_ok = 0;
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("ct_s_addr_hold", s_if.addr, 32'h8000_0010);
      chk("ct_d_addr_ok_wait", d_if.addr_ok, 1'b0);
      nxt();
    end
    s_if.addr_ok = 1;
    neg();
    chk("ct_d_addr_ok", d_if.addr_ok, 1'b1);
    chk("ct_i_addr_ok_none", i_if.addr_ok, 1'b0);
    nxt();
    d_if.req = 0; d_if.wr = 0;
    neg();
    chk("ct_i_next_addr", s_if.addr, 32'h0000_1000);
    chk("ct_i_addr_ok", i_if.addr_ok, 1'b1);
    nxt(); idle();
    s_if.data_ok = 1; s_if.rdata = 32'h1111_2222;
    neg(); chk("ct_ret_d", d_if.data_ok, 1'b1);
    nxt(); s_if.rdata = 32'h3333_4444;
    neg(); chk("ct_ret_i", i_if.data_ok, 1'b1);
    nxt(); idle();

    // back-to-back I, D, I then in-order returns
    s_if.addr_ok = 1;
    i_if.req = 1; nxt();
    i_if.req = 0; d_if.req = 1; nxt();
    d_if.req = 0; i_if.req = 1; nxt();
    idle();
    neg(); chk("oo_peak", 32'(outstanding), 3);
    nxt();
    s_if.data_ok = 1; s_if.rdata = 32'hA0A0_0001;
    neg(); chk("oo_ret1_i", i_if.data_ok, 1'b1);
    nxt(); s_if.rdata = 32'hA0A0_0002;
    neg(); chk("oo_ret2_d", d_if.data_ok, 1'b1);
    chk("oo_ret2_d_rdata", d_if.rdata, 32'hA0A0_0002);
    nxt(); s_if.rdata = 32'hA0A0_0003;
    neg(); chk("oo_ret3_i", i_if.data_ok, 1'b1);
    nxt(); idle();
    neg(); chk("oo_out0", 32'(outstanding), 0);
    nxt();

    // full: I, D, I, D accepted, fifth request blocked
    s_if.addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      i_if.req = (k % 2 == 0);
      d_if.req = (k % 2 == 1);
      nxt();
    end
    i_if.req = 0; d_if.req = 1;
    neg();
    chk("fl_out4", 32'(outstanding), 4);
    chk("fl_s_req", s_if.req, 1'b0);
    chk("fl_d_addr_ok", d_if.addr_ok, 1'b0);
    nxt();
    s_if.data_ok = 1;
    neg();
    chk("fl_s_req_pop", s_if.req, 1'b0);
    chk("fl_pop_i", i_if.data_ok, 1'b1);
    nxt();
    s_if.data_ok = 0;
    neg();
    chk("fl_s_req_reopen", s_if.req, 1'b1);
    chk("fl_d_addr_ok2", d_if.addr_ok, 1'b1);
    chk("fl_out3", 32'(outstanding), 3);
    nxt();
    // queue now D,I,D,D: drain two
    d_if.req = 0; s_if.addr_ok = 0; s_if.data_ok = 1;
    nxt(); nxt();
    // simultaneous push (I) and pop (head D) at count 2
    i_if.req = 1; s_if.addr_ok = 1; s_if.data_ok = 1;
    neg();
    chk("pp_out2", 32'(outstanding), 2);
    chk("pp_d_data_ok", d_if.data_ok, 1'b1);
    chk("pp_i_addr_ok", i_if.addr_ok, 1'b1);
    nxt(); idle();
    neg(); chk("pp_out_still2", 32'(outstanding), 2);
    nxt();
    s_if.data_ok = 1;
    neg(); chk("pp_drain_d", d_if.data_ok, 1'b1);
    nxt();
    neg(); chk("pp_drain_i", i_if.data_ok, 1'b1);
    nxt(); idle();
    neg(); chk("pp_out0", 32'(outstanding), 0);
    nxt();

    // lock on I is not stolen by a later D request
    i_if.req = 1; i_if.addr = 32'h0000_2000; s_if.addr_ok = 0;
    nxt();
    d_if.req = 1;
    neg(); chk("lk_s_addr_i", s_if.addr, 32'h0000_2000);
    nxt();
    s_if.addr_ok = 1;
    neg();
    chk("lk_i_addr_ok", i_if.addr_ok, 1'b1);
    chk("lk_d_addr_ok_none", d_if.addr_ok, 1'b0);
    nxt();
    i_if.req = 0;
    neg(); chk("lk_d_addr_ok", d_if.addr_ok, 1'b1);
    nxt(); idle();
    s_if.data_ok = 1; nxt(); nxt(); idle();
    nxt();

    // data_ok with empty queue
    s_if.data_ok = 1;
    neg();
    chk("er_i_data_ok", i_if.data_ok, 1'b0);
    chk("er_d_data_ok", d_if.data_ok, 1'b0);
    nxt(); idle();
    neg(); chk("er_err_set", protocol_err, 1'b1);
    nxt(); nxt(); nxt();
    neg(); chk("er_err_sticky", protocol_err, 1'b1);
    nxt();

    // reset while D holds the lock
    d_if.req = 1; s_if.addr_ok = 0;
    nxt();
    rst = 1; i_if.req = 1;
    neg(); chk("rh_s_req_rst", s_if.req, 1'b0);
    nxt();
    rst = 0; d_if.req = 0; i_if.req = 1; s_if.addr_ok = 1; s_if.data_ok = 1;
    neg();
    chk("rh_out0", 32'(outstanding), 0);
    chk("rh_err_clr", protocol_err, 1'b0);
    chk("rh_i_addr_ok", i_if.addr_ok, 1'b1);
    chk("rh_late_dok", i_if.data_ok, 1'b0);
    nxt(); idle();
    neg();
    chk("rh_out1", 32'(outstanding), 1);
    chk("rh_err_late", protocol_err, 1'b1);
    nxt();
    s_if.data_ok = 1;
    neg(); chk("rh_ret_i", i_if.data_ok, 1'b1);
    nxt(); idle();

    // locked master drops req
    rst = 1; nxt(); rst = 0;
    d_if.req = 1; s_if.addr_ok = 0;
    nxt();
    d_if.req = 0;
    neg();
    chk("dr_s_req", s_if.req, 1'b0);
    chk("dr_err_before", protocol_err, 1'b0);
    nxt();
    neg(); chk("dr_err_set", protocol_err, 1'b1);
    nxt(); nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
